icache_direct: RTL

- Direct-mapped, read-only instruction cache between the instruction fetch stage and the memory bus.
- Serves one 32-bit instruction word per ic_req/ic_ack handshake.
- On a miss, refills a full 64-byte line over the tagged request/response bus (8 beats of 64 bits), then answers from the filled line.
- One outstanding miss at a time; no write path. Flush invalidates all lines.

---
 rtl/icache_pkg.sv | 10 +
 rtl/icache_array.sv | 51 +++++
 rtl/icache_direct.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared constants and types for the direct-mapped instruction cache.
package icache_pkg;
  localparam logic [12:0] TAG_IFETCH_READ = 13'h1001;
  localparam int LINE_BEATS  = 8;
  localparam int BEAT_W      = $clog2(LINE_BEATS);
  localparam int LINE_ADDR_W = 58;
  localparam int WORD_SEL_W  = 4;

  typedef enum logic [2:0] {IDLE, LOOKUP, REQ, FILL, ACK} state_t;
endpackage

// File: rtl/icache_array.sv
// Tag, valid and line storage: synchronous writes, combinational read by index.
module icache_array
  import icache_pkg::*;
#(
  parameter int NUM_SETS = 64,
  parameter int DATA_W   = 64,
  parameter int IDX_W    = $clog2(NUM_SETS),
  parameter int TAG_W    = LINE_ADDR_W - IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              inval_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic              data_we,
  input  logic [BEAT_W-1:0] wr_beat,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              tag_we,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [BEAT_W-1:0] rd_beat,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data
);
  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
  logic [DATA_W-1:0]   data_mem [NUM_SETS][LINE_BEATS];

  // Flush wins over everything; invalidation at fill start keeps partial lines unhittable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (inval_en) begin
      valid_q[wr_idx] <= 1'b0;
    end else if (tag_we) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we) data_mem[wr_idx][wr_beat] <= wr_data;
    if (tag_we)  tag_mem[wr_idx] <= wr_tag;
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx][rd_beat];
endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache; refills 64-byte lines over a tagged bus.
// Handshakes: ic_req is a level held until the one-cycle ic_ack; bus_reqcyc holds until bus_reqack; a beat is taken when bus_respcyc && bus_respack.
module icache_direct
  import icache_pkg::*;
#(
  parameter int NUM_SETS       = 64,
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ic_req,
  input  logic [LINE_ADDR_W-1:0]    ic_line_addr,
  input  logic [WORD_SEL_W-1:0]     ic_word_select,
  input  logic                      ic_flush,
  output logic                      ic_ack,
  output logic [63:0]               ic_data_out,
  output logic                      bus_reqcyc,
  output logic [63:0]               bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack,
  output state_t                    dbg_state
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = LINE_ADDR_W - IDX_W;
  localparam logic [BUS_TAG_WIDTH-1:0] FETCH_TAG = BUS_TAG_WIDTH'(TAG_IFETCH_READ);

  state_t                 state;
  logic [LINE_ADDR_W-1:0] line_q;
  logic [WORD_SEL_W-1:0]  word_q;
  logic [BEAT_W-1:0]      beat_cnt;
  logic                   flush_pend;

  logic [IDX_W-1:0]          idx_q;
  logic [TAG_W-1:0]          tag_q;
  logic [BEAT_W-1:0]         beat_sel;
  logic                      rd_valid;
  logic [TAG_W-1:0]          rd_tag;
  logic [BUS_DATA_WIDTH-1:0] rd_data;
  logic                      hit;
  logic                      fill_done;
  logic                      flush_now;
  logic [31:0]               rd_word;
  logic [31:0]               fill_word;

  assign idx_q    = line_q[IDX_W-1:0];
  assign tag_q    = line_q[LINE_ADDR_W-1:IDX_W];
  assign beat_sel = word_q[3:1];

  assign bus_reqcyc  = (state == REQ);
  assign bus_req     = {line_q, 6'b0};
  assign bus_reqtag  = FETCH_TAG;
  assign bus_respack = (state == FILL) && bus_respcyc && (bus_resptag == FETCH_TAG);
  assign dbg_state   = state;

  assign hit       = rd_valid && (rd_tag == tag_q);
  assign fill_done = bus_respack && (beat_cnt == BEAT_W'(LINE_BEATS - 1));
  assign rd_word   = word_q[0] ? rd_data[63:32]  : rd_data[31:0];
  assign fill_word = word_q[0] ? bus_resp[63:32] : bus_resp[31:0];

  // A flush seen mid-transaction is applied as the ack completes, after the word is delivered.
  assign flush_now = ((state == IDLE) && ic_flush) ||
                     ((state == ACK) && (flush_pend || ic_flush));

  icache_array #(
    .NUM_SETS (NUM_SETS),
    .DATA_W   (BUS_DATA_WIDTH)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush_now),
    .inval_en ((state == REQ) && bus_reqack),
    .wr_idx   (idx_q),
    .data_we  (bus_respack),
    .wr_beat  (beat_cnt),
    .wr_data  (bus_resp),
    .tag_we   (fill_done),
    .wr_tag   (tag_q),
    .rd_idx   (idx_q),
    .rd_beat  (beat_sel),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      line_q      <= '0;
      word_q      <= '0;
      beat_cnt    <= '0;
      flush_pend  <= 1'b0;
      ic_ack      <= 1'b0;
      ic_data_out <= '0;
    end else begin
      ic_ack <= 1'b0;
      if (ic_flush && (state != IDLE) && (state != ACK)) flush_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (ic_req && !ic_flush) begin
            line_q <= ic_line_addr;
            word_q <= ic_word_select;
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            state       <= ACK;
            ic_ack      <= 1'b1;
            ic_data_out <= {32'b0, rd_word};
          end else begin
            state <= REQ;
          end
        end
        REQ: begin
          if (bus_reqack) begin
            state    <= FILL;
            beat_cnt <= '0;
          end
        end
        FILL: begin
          if (bus_respack) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (fill_done) begin
              state       <= ACK;
              ic_ack      <= 1'b1;
              // The requested word may be in the beat arriving right now, not yet in the array.
              ic_data_out <= {32'b0, (beat_sel == BEAT_W'(LINE_BEATS - 1)) ? fill_word : rd_word};
            end
          end
        end
        ACK: begin
          state      <= IDLE;
          flush_pend <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
